// File: rtl/pll_lock_reset_seq_pkg.sv
// rtl/pll_lock_reset_seq_pkg.sv - shared state encoding, defaults and counter-width helper for the PLL lock/reset sequencer
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_SYNC_STAGES   = 2;

  // Bits needed for a counter that can represent the largest of the three limits.
  function automatic int cnt_w_for(input int rst_cycles, input int lock_timeout,
                                   input int stable_cycles);
    int m;
    m = rst_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (stable_cycles > m) m = stable_cycles;
    return $clog2(m + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_w_for(DEF_RST_CYCLES, DEF_LOCK_TIMEOUT, DEF_STABLE_CYCLES);

endpackage

// File: rtl/pll_lock_reset_seq_if.sv
// rtl/pll_lock_reset_seq_if.sv - PLL-side and system-side signals of the sequencer; PLL_LOCK_LOSS_COUNT_EN adds the loss counter
interface pll_lock_reset_seq_if;

  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset_n;
  logic [1:0] seq_state;
  logic       timeout_pulse;
  logic       lock_lost_pulse;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
  logic       count_clr;
`endif

  // Sequencer side
  modport slave (
    input  pll_locked,
`ifdef PLL_LOCK_LOSS_COUNT_EN
    input  count_clr,
    output lock_loss_count,
`endif
    output pll_rst,
    output sys_reset_n,
    output seq_state,
    output timeout_pulse,
    output lock_lost_pulse
  );

  // PLL / supervisor side
  modport master (
    output pll_locked,
`ifdef PLL_LOCK_LOSS_COUNT_EN
    output count_clr,
    input  lock_loss_count,
`endif
    input  pll_rst,
    input  sys_reset_n,
    input  seq_state,
    input  timeout_pulse,
    input  lock_lost_pulse
  );

endinterface

// File: rtl/pll_lock_reset_seq_sync_bit.sv
// rtl/pll_lock_reset_seq_sync_bit.sv - multi-flop single-bit synchroniser with synchronous active-low reset
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// rtl/pll_lock_reset_seq.sv - PLL reset / lock qualification sequencer; PLL_LOCK_LOSS_COUNT_EN adds a saturating loss counter
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 reset_n,
  pll_lock_reset_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  seq_state_e       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic             r_pll_rst, r_sys_reset_n, r_timeout, r_lock_lost;
  logic             w_timeout, w_lock_lost;
  logic             w_locked_s, w_sync_rst_n;

  // The PLL's lock flag is meaningless while it is held in reset, so the
  // synchroniser is cleared then; a stale high cannot leak into WAIT_LOCK.
  assign w_sync_rst_n = reset_n & ~r_pll_rst;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (w_sync_rst_n),
    .i_d     (bus.pll_locked),
    .o_q     (w_locked_s)
  );

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // Next-state, next-count and event decode.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = w_cnt_inc;
    w_timeout   = 1'b0;
    w_lock_lost = 1'b0;
    case (r_state)
      PLL_RESET: begin
        if (r_cnt == RST_LAST) begin
          w_cnt_d   = '0;
          w_state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_cnt_d   = '0;
          w_state_d = STABLE;
        end else if (r_cnt == TO_LAST) begin
          w_timeout = 1'b1;
          w_cnt_d   = '0;
          w_state_d = PLL_RESET;
        end
      end
      STABLE: begin
        if (!w_locked_s) begin
          w_cnt_d   = '0;
          w_state_d = WAIT_LOCK;
        end else if (r_cnt == STABLE_LAST) begin
          w_cnt_d   = '0;
          w_state_d = RUN;
        end
      end
      RUN: begin
        w_cnt_d = '0;
        if (!w_locked_s) begin
          w_lock_lost = 1'b1;
          w_state_d   = PLL_RESET;
        end
      end
      default: begin
        w_cnt_d   = '0;
        w_state_d = PLL_RESET;
      end
    endcase
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= PLL_RESET;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_timeout     <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_pll_rst     <= (w_state_d == PLL_RESET);
      r_sys_reset_n <= (w_state_d == RUN);
      r_timeout     <= w_timeout;
      r_lock_lost   <= w_lock_lost;
    end
  end

  assign bus.pll_rst         = r_pll_rst;
  assign bus.sys_reset_n     = r_sys_reset_n;
  assign bus.seq_state       = r_state;
  assign bus.timeout_pulse   = r_timeout;
  assign bus.lock_lost_pulse = r_lock_lost;

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0] r_loss_cnt;

  // Saturating event count; a clear on the same cycle as an event wins.
  always_ff @(posedge clk) begin
    if (!reset_n)                                       r_loss_cnt <= '0;
    else if (bus.count_clr)                             r_loss_cnt <= '0;
    else if ((w_timeout | w_lock_lost) && r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'd1;
  end

  assign bus.lock_loss_count = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb/tb_pll_lock_reset_seq.sv - segment-table bench for pll_lock_reset_seq; PLL_LOCK_LOSS_COUNT_EN enables the counter checks
module tb_pll_lock_reset_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  pll_lock_reset_seq_if u_if();

  pll_lock_reset_seq #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .SYNC_STAGES   (2),
    .CNT_W         (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  typedef struct {
    int         n;
    logic       locked;
    logic [1:0] st;
    logic       prst;
    logic       srn;
    logic       to;
    logic       ll;
  } seg_t;

  seg_t tbl[$];

  task automatic add(input int n, input logic locked, input logic [1:0] st,
                     input logic prst, input logic srn, input logic to, input logic ll);
    seg_t s;
    s.n = n; s.locked = locked; s.st = st; s.prst = prst; s.srn = srn; s.to = to; s.ll = ll;
    tbl.push_back(s);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic prst,
                            input logic srn, input logic to, input logic ll);
    check({tag, ".seq_state"},       32'(u_if.seq_state),       32'(st));
    check({tag, ".pll_rst"},         32'(u_if.pll_rst),         32'(prst));
    check({tag, ".sys_reset_n"},     32'(u_if.sys_reset_n),     32'(srn));
    check({tag, ".timeout_pulse"},   32'(u_if.timeout_pulse),   32'(to));
    check({tag, ".lock_lost_pulse"}, 32'(u_if.lock_lost_pulse), 32'(ll));
  endtask

  // Each row holds for n cycles; cycle 0 is the first cycle with reset_n released.
  task automatic run_rows(input string tag, input int lo, input int hi);
    cyc = 0;
    for (int i = lo; i <= hi; i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        @(negedge clk);
        reset_n = 1'b1;
        u_if.pll_locked = tbl[i].locked;
        check_outs($sformatf("%s.row%0d", tag, i), tbl[i].st, tbl[i].prst, tbl[i].srn,
                   tbl[i].to, tbl[i].ll);
        cyc++;
      end
    end
  endtask

  initial begin
    int a_lo, a_hi, b_lo, b_hi;
    u_if.pll_locked = 1'b0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    u_if.count_clr = 1'b0;
`endif

    // Scenario A: lock from cycle 0, run, lose lock, relock with a glitch in STABLE.
    a_lo = tbl.size();
    add(4, 1, 2'd0, 1, 0, 0, 0);  // c0-3   PLL reset pulse
    add(3, 1, 2'd1, 0, 0, 0, 0);  // c4-6   WAIT_LOCK while synchroniser fills
    add(8, 1, 2'd2, 0, 0, 0, 0);  // c7-14  STABLE
    add(5, 1, 2'd3, 0, 1, 0, 0);  // c15-19 RUN, sys_reset_n up at 4+2+8+1
    add(3, 0, 2'd3, 0, 1, 0, 0);  // c20-22 lock dropped, still RUN through sync
    add(1, 1, 2'd0, 1, 0, 0, 1);  // c23    lock-lost pulse, PLL reset
    add(3, 1, 2'd0, 1, 0, 0, 0);  // c24-26
    add(3, 1, 2'd1, 0, 0, 0, 0);  // c27-29 WAIT_LOCK
    add(2, 1, 2'd2, 0, 0, 0, 0);  // c30-31 STABLE
    add(1, 0, 2'd2, 0, 0, 0, 0);  // c32    one-cycle glitch on pll_locked
    add(2, 1, 2'd2, 0, 0, 0, 0);  // c33-34
    add(1, 1, 2'd1, 0, 0, 0, 0);  // c35    back to WAIT_LOCK, no PLL reset
    add(8, 1, 2'd2, 0, 0, 0, 0);  // c36-43 STABLE restarts
    add(4, 1, 2'd3, 0, 1, 0, 0);  // c44-47 RUN
    a_hi = tbl.size() - 1;

    // Scenario B: never locks, timeout every 24 cycles.
    b_lo = tbl.size();
    add(4,  0, 2'd0, 1, 0, 0, 0);
    add(20, 0, 2'd1, 0, 0, 0, 0);
    add(1,  0, 2'd0, 1, 0, 1, 0);
    add(3,  0, 2'd0, 1, 0, 0, 0);
    add(20, 0, 2'd1, 0, 0, 0, 0);
    add(1,  0, 2'd0, 1, 0, 1, 0);
    add(3,  0, 2'd0, 1, 0, 0, 0);
    add(20, 0, 2'd1, 0, 0, 0, 0);
    b_hi = tbl.size() - 1;

    repeat (3) @(negedge clk);
    check_outs("in_reset", 2'd0, 1, 0, 0, 0);

    run_rows("A", a_lo, a_hi);

    // Reset while in RUN: one edge later everything is back at reset values.
    @(negedge clk);
    reset_n = 1'b0;
    u_if.pll_locked = 1'b0;
    @(negedge clk);
    check_outs("reset_in_run", 2'd0, 1, 0, 0, 0);

    run_rows("B", b_lo, b_hi);

`ifdef PLL_LOCK_LOSS_COUNT_EN
    begin
      int waited;
      @(negedge clk);
      reset_n = 1'b0;
      u_if.pll_locked = 1'b0;
      @(negedge clk);
      check("cnt.reset", 32'(u_if.lock_loss_count), 32'd0);
      reset_n = 1'b1;
      repeat (300 * 24 + 8) @(negedge clk);
      check("cnt.saturate", 32'(u_if.lock_loss_count), 32'd255);
      waited = 0;
      while (u_if.timeout_pulse !== 1'b1 && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      check("cnt.pulse_seen", 32'(u_if.timeout_pulse), 32'd1);
      repeat (23) @(negedge clk);
      u_if.count_clr = 1'b1;
      @(negedge clk);
      u_if.count_clr = 1'b0;
      check("cnt.clr_pulse", 32'(u_if.timeout_pulse), 32'd1);
      check("cnt.clr_wins", 32'(u_if.lock_loss_count), 32'd0);
      repeat (24) @(negedge clk);
      check("cnt.after_clr_pulse", 32'(u_if.timeout_pulse), 32'd1);
      check("cnt.after_clr", 32'(u_if.lock_loss_count), 32'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
